// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box constants, FSM state type and GF(2^8) helper.
// Imported by gf256_mul and inv_sbox_iter.
package aes_sbox_pkg;

  localparam logic [7:0] INV_AFFINE_C = 8'h05;
  localparam logic [7:0] FWD_AFFINE_C = 8'h63;
  localparam logic [8:0] GF_POLY      = 9'h11B;
  localparam logic [7:0] INV_EXP      = 8'hFE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXP  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply by x, reduced mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(
    input logic [7:0] a
  );
    logic [7:0] s;
    s = {a[6:0], 1'b0};
    if (a[7]) s = s ^ GF_POLY[7:0];
    return s;
  endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational 8x8 GF(2^8) multiplier, AES polynomial 0x11B.
// Ports: i_a, i_b operands; o_p product.
module gf256_mul
  import aes_sbox_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p
);

  logic [7:0] w_acc;
  logic [7:0] w_sh;

  // Shift-and-add with reduction folded into each shift.
  always_comb begin
    w_acc = 8'h00;
    w_sh  = i_a;
    for (int i = 0; i < 8; i++) begin
      if (i_b[i]) w_acc = w_acc ^ w_sh;
      w_sh = gf_xtime(w_sh);
    end
  end

  assign o_p = w_acc;

endmodule

// File: rtl/inv_sbox_iter.sv
// Iterative AES inverse S-box: inverse affine, then x^254 by
// square-and-multiply, one exponent bit per cycle.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready
// input handshake; out_data/out_valid/out_ready output handshake;
// out_err self-check flag (only live with INV_SBOX_CHECK_EN).
module inv_sbox_iter
  import aes_sbox_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_err
);

  state_e     r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_t;
  logic [7:0] r_r;
  logic [7:0] r_out;
  logic       r_valid;
  logic       r_err;

  logic [7:0] w_t;
  logic [7:0] w_sq;
  logic [7:0] w_mulb;
  logic [7:0] w_next;
  logic       w_err;

  // Inverse affine transform.
  always_comb begin
    w_t = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_t[i] = in_data[(i + 2) % 8]
             ^ in_data[(i + 5) % 8]
             ^ in_data[(i + 7) % 8]
             ^ INV_AFFINE_C[i];
    end
  end

  gf256_mul u_sq (
    .i_a (r_r),
    .i_b (r_r),
    .o_p (w_sq)
  );

  assign w_mulb = INV_EXP[r_cnt] ? r_t : 8'h01;

  gf256_mul u_mul (
    .i_a (w_sq),
    .i_b (w_mulb),
    .o_p (w_next)
  );

`ifdef INV_SBOX_CHECK_EN
  logic [7:0] w_p;

  gf256_mul u_chk (
    .i_a (r_t),
    .i_b (w_next),
    .o_p (w_p)
  );

  // t * t^-1 must be 1; zero maps to zero.
  assign w_err = (r_t != 8'h00) ? (w_p != 8'h01)
                                : (w_next != 8'h00);
`else
  assign w_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_t     <= 8'h00;
      r_r     <= 8'h01;
      r_out   <= 8'h00;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_t     <= w_t;
            r_r     <= 8'h01;
            r_cnt   <= 3'd7;
            r_state <= EXP;
          end
        end
        EXP: begin
          r_r   <= w_next;
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            r_out   <= w_next;
            r_err   <= w_err;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) & ~rst;
  assign out_data  = r_out;
  assign out_valid = r_valid;
  assign out_err   = r_err;

endmodule

// File: tb/tb_inv_sbox_iter.sv
// Self-checking bench for inv_sbox_iter against a table model
// built from GF arithmetic and the forward AES S-box.
module tb_inv_sbox_iter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_q[$];

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  inv_sbox_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_q.push_back(cyc);
  end

  // Full polynomial product, then long division by 0x11B.
  function automatic logic [7:0] ref_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 15; k >= 8; k--)
      if (p[k]) p = p ^ (16'h11B << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] x,
    input int n
  );
    logic [7:0] r;
    r = (x << n) | (x >> (8 - n));
    return r;
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] x;
    logic [7:0] s;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h00;
      if (x != 8'h00)
        for (int c = 1; c < 256; c++)
          if (ref_mul(x, 8'(c)) == 8'h01) inv = 8'(c);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
        ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[v]  = s;
      isbox[s] = x;
    end
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after one.
  task automatic xact(
    input  logic [7:0] y,
    output logic [7:0] d,
    output logic       e,
    output int         lat
  );
    int w;
    in_data  = y;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    d = out_data;
    e = out_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic wait_valid();
    int w;
    w = 0;
    while (!out_valid && w < 40) begin
      @(posedge clk); #1; w++;
    end
    chk("wait_valid", 32'(out_valid), 1);
  endtask

  initial begin
    logic [7:0] d;
    logic       e;
    int         lat;
    logic [7:0] y;
    logic [7:0] held;
    int         nacc;
    int         w;
    logic [7:0] dir_in  [5];
    logic [7:0] dir_exp [5];

    dir_in  = '{8'h63, 8'h7C, 8'h00, 8'hED, 8'hFF};
    dir_exp = '{8'h00, 8'h01, 8'h52, 8'h53, 8'h7D};
    build_tables();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_err", 32'(out_err), 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 1);
    chk("rel_out_valid", 32'(out_valid), 0);

    for (int i = 0; i < 5; i++) begin
      xact(dir_in[i], d, e, lat);
      chk($sformatf("dir_%0h", dir_in[i]), 32'(d), 32'(dir_exp[i]));
      chk("dir_lat", 32'(lat), 8);
      chk("dir_err", 32'(e), 0);
    end

    for (int v = 0; v < 256; v++) begin
      y = 8'(v);
      xact(y, d, e, lat);
      chk($sformatf("sweep_%0h", y), 32'(d), 32'(isbox[y]));
      chk("sweep_rt", 32'(sbox[d]), 32'(y));
      chk("sweep_err", 32'(e), 0);
      chk("sweep_lat", 32'(lat), 8);
    end

    for (int i = 0; i < 24; i++) begin
      y = 8'($urandom);
      xact(y, d, e, lat);
      chk($sformatf("rnd_%0h", y), 32'(d), 32'(isbox[y]));
      chk("rnd_lat", 32'(lat), 8);
    end

    in_data  = 8'hED;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid();
    held = out_data;
    chk("bp_data", 32'(held), 32'(isbox[8'hED]));
    nacc = acc_q.size();
    in_data  = 8'h00;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_stable", 32'(out_data), 32'(held));
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    chk("bp_no_acc", 32'(acc_q.size()), 32'(nacc));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", 32'(in_ready), 1);
    chk("bp_valid_lo", 32'(out_valid), 0);

    acc_q.delete();
    in_data   = 8'h7C;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    in_valid = 1'b0;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    out_ready = 1'b0;
    chk("b2b_idle", 32'(in_ready), 1);
    chk("b2b_count", 32'(acc_q.size()), 5);
    for (int i = 1; i < acc_q.size(); i++)
      chk("b2b_gap", 32'(acc_q[i] - acc_q[i-1]), 10);
    chk("b2b_last", 32'(out_data), 32'(8'h01));

    in_data  = 8'h63;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_idle", 32'(in_ready), 1);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_quiet", 32'(out_valid), 0);
    xact(8'h63, d, e, lat);
    chk("post_rst_63", 32'(d), 0);
    chk("post_rst_lat", 32'(lat), 8);

`ifdef INV_SBOX_CHECK_EN
    in_data  = 8'h7C;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    force dut.r_r = 8'h5A;
    @(posedge clk); #1;
    release dut.r_r;
    wait_valid();
    chk("force_err", 32'(out_err), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
